// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: shares one combinational ALU between two requesters.
// Requests are arbitrated round-robin over valid/ready handshakes. Operands
// are held on the ALU for an opcode-dependent number of cycles. The ALU result
// and carry are then registered and returned over a valid/ready response
// handshake to the requester that was granted.
// Optional build macro: ALU_SCHED_DIVZERO_CHECK_EN. When it is defined, a mod
// by zero bypasses the slow path and responds with result 0, carry 0, err 1.
module alu_req_scheduler #(
    parameter int N          = 32,
    parameter int MUL_CYCLES = 2,
    parameter int MOD_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_opcode,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_opcode,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         resp0_valid,
    input  logic         resp0_ready,
    output logic [N-1:0] resp0_result,
    output logic         resp0_carry,
    output logic         resp0_err,
    output logic         resp1_valid,
    input  logic         resp1_ready,
    output logic [N-1:0] resp1_result,
    output logic         resp1_carry,
    output logic         resp1_err,
    output logic [3:0]   alu_opcode,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_result,
    input  logic         alu_carry,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_MOD = 4'b0011;

    logic [1:0]   state;
    logic         last_grant;
    logic         grant;
    logic [3:0]   counter;
    logic [3:0]   opcode_r;
    logic [N-1:0] a_r;
    logic [N-1:0] b_r;
    logic [N-1:0] result_r;
    logic         carry_r;
`ifdef ALU_SCHED_DIVZERO_CHECK_EN
    logic         err_r;
    logic         divz_r;
`endif

    logic         any_valid;
    logic         sel;
    logic [3:0]   sel_opcode;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;

    // The counter is loaded with EXEC cycles minus one, so 0 means a single EXEC cycle.
    function automatic logic [3:0] exec_count(input logic [3:0] op);
        case (op)
            OP_MUL:  exec_count = 4'(MUL_CYCLES - 1);
            OP_MOD:  exec_count = 4'(MOD_CYCLES - 1);
            default: exec_count = 4'd0;
        endcase
    endfunction

    // Round-robin pick: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        sel       = 1'b0;
        if (req0_valid && req1_valid)
            sel = ~last_grant;
        else if (req1_valid)
            sel = 1'b1;
        sel_opcode = sel ? req1_opcode : req0_opcode;
        sel_a      = sel ? req1_a      : req0_a;
        sel_b      = sel ? req1_b      : req0_b;
    end

    // Ready is offered only in IDLE and is forced low while reset is asserted.
    assign req0_ready = !rst && (state == S_IDLE) && req0_valid && !sel;
    assign req1_ready = !rst && (state == S_IDLE) && req1_valid &&  sel;

    assign resp0_valid  = (state == S_RESP) && !grant;
    assign resp1_valid  = (state == S_RESP) &&  grant;
    assign resp0_result = result_r;
    assign resp1_result = result_r;
    assign resp0_carry  = carry_r;
    assign resp1_carry  = carry_r;
`ifdef ALU_SCHED_DIVZERO_CHECK_EN
    assign resp0_err    = err_r;
    assign resp1_err    = err_r;
`else
    assign resp0_err    = 1'b0;
    assign resp1_err    = 1'b0;
`endif

    // The ALU sees only the issue registers, so its inputs stay put outside EXEC.
    assign alu_opcode = opcode_r;
    assign alu_a      = a_r;
    assign alu_b      = b_r;
    assign busy       = (state != S_IDLE);

    // Scheduler FSM: accept, hold operands for the opcode's budget, capture, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            counter    <= 4'd0;
            opcode_r   <= 4'd0;
            a_r        <= '0;
            b_r        <= '0;
            result_r   <= '0;
            carry_r    <= 1'b0;
`ifdef ALU_SCHED_DIVZERO_CHECK_EN
            err_r      <= 1'b0;
            divz_r     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant    <= sel;
                        opcode_r <= sel_opcode;
                        a_r      <= sel_a;
                        b_r      <= sel_b;
                        counter  <= exec_count(sel_opcode);
`ifdef ALU_SCHED_DIVZERO_CHECK_EN
                        err_r    <= 1'b0;
                        divz_r   <= 1'b0;
                        if (sel_opcode == OP_MOD && sel_b == '0) begin
                            counter <= 4'd0;
                            divz_r  <= 1'b1;
                        end
`endif
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (counter == 4'd0) begin
                        result_r <= alu_result;
                        carry_r  <= alu_carry;
`ifdef ALU_SCHED_DIVZERO_CHECK_EN
                        if (divz_r) begin
                            result_r <= '0;
                            carry_r  <= 1'b0;
                            err_r    <= 1'b1;
                        end
`endif
                        state <= S_RESP;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                S_RESP: begin
                    if (grant ? resp1_ready : resp0_ready) begin
                        last_grant <= grant;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb_alu_req_scheduler: random two-requester traffic against a transaction-level
// reference model that tracks, for each accepted op, its owner, its expected
// result and the cycle at which its response becomes due.
// Honours ALU_SCHED_DIVZERO_CHECK_EN in the same way as the design.
module tb_alu_req_scheduler;

    localparam int N      = 32;
    localparam int MUL_C  = 2;
    localparam int MOD_C  = 4;
    localparam int CYCLES = 4000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_opcode, req1_opcode;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp0_valid, resp1_valid;
    logic         resp0_ready, resp1_ready;
    logic [N-1:0] resp0_result, resp1_result;
    logic         resp0_carry, resp1_carry, resp0_err, resp1_err;
    logic [3:0]   alu_opcode;
    logic [N-1:0] alu_a, alu_b, alu_result;
    logic         alu_carry;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    alu_req_scheduler #(.N(N), .MUL_CYCLES(MUL_C), .MOD_CYCLES(MOD_C)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp0_carry(resp0_carry), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .resp1_carry(resp1_carry), .resp1_err(resp1_err),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU used both as the DUT's ALU and for expected results.
    function automatic logic [N:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
        logic [N:0] r;
        case (op)
            4'b0000: r = {1'b0, a} + {1'b0, b};
            4'b0001: r = {(a < b), a - b};
            4'b0010: r = {1'b0, a * b};
            4'b0011: r = (b == 0) ? '0 : {1'b0, a % b};
            4'b0100: r = {1'b0, a & b};
            4'b0101: r = {1'b0, a | b};
            4'b1000: r = {1'b0, a << b[4:0]};
            4'b1001: r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb {alu_carry, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Requester-side pending ops
    logic         v [2];
    logic [3:0]   p_op [2];
    logic [N-1:0] p_a [2];
    logic [N-1:0] p_b [2];
    logic         hs [2];

    // Reference model state
    logic         inflight;
    logic         owner;
    logic         last;
    int           resp_start;
    logic [N-1:0] e_res;
    logic         e_car, e_err;
    logic [3:0]   e_op;
    logic [N-1:0] e_a, e_b;

    task automatic model_reset();
        inflight = 1'b0; owner = 1'b0; last = 1'b1; resp_start = 0;
        e_res = '0; e_car = 1'b0; e_err = 1'b0;
        e_op = '0; e_a = '0; e_b = '0;
    endtask

    task automatic drive_ports();
        req0_valid = v[0]; req0_opcode = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
        req1_valid = v[1]; req1_opcode = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
    endtask

    task automatic new_op(input int k);
        int sel_a, sel_b;
        p_op[k] = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) p_op[k] = 4'b0011;
        sel_a = $urandom_range(0, 3);
        sel_b = $urandom_range(0, 3);
        p_a[k] = (sel_a == 0) ? 32'hFFFF_FFFF : (sel_a == 1) ? 32'($urandom_range(0, 200)) : $urandom;
        p_b[k] = (sel_b == 0) ? 32'($urandom_range(0, 3)) : (sel_b == 1) ? 32'($urandom_range(0, 40)) : $urandom;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_req0_ready"},  req0_ready,  '0);
        chk({pfx, "_req1_ready"},  req1_ready,  '0);
        chk({pfx, "_resp0_valid"}, resp0_valid, '0);
        chk({pfx, "_resp1_valid"}, resp1_valid, '0);
        chk({pfx, "_busy"},        busy,        '0);
        chk({pfx, "_alu_opcode"},  alu_opcode,  '0);
        chk({pfx, "_alu_a"},       alu_a,       '0);
        chk({pfx, "_alu_b"},       alu_b,       '0);
        chk({pfx, "_result"},      resp0_result, '0);
        chk({pfx, "_carry"},       resp0_carry, '0);
        chk({pfx, "_err"},         resp0_err,   '0);
    endtask

    initial begin
        int n_rst;
        logic both, sel, er0, er1, ev0, ev1, idle;
        logic [N:0] r;
        int lat;

        n_rst = 0;
        for (int k = 0; k < 2; k++) begin
            v[k] = 1'b1; hs[k] = 1'b0; new_op(k);
        end
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        drive_ports();
        model_reset();

        // Reset state, with both requesters already valid: ready must stay low.
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            // Stimulus for this cycle
            for (int k = 0; k < 2; k++) begin
                if (!v[k] || hs[k]) begin
                    v[k] = ($urandom_range(0, 2) != 0);
                    if (v[k]) new_op(k);
                end
                hs[k] = 1'b0;
            end
            drive_ports();
            resp0_ready = ($urandom_range(0, 1) == 1);
            resp1_ready = ($urandom_range(0, 2) != 0);

            // Asynchronous reset pulse in the middle of an operation's EXEC phase.
            if (inflight && cyc < resp_start && n_rst < 4 && cyc > 500 * (n_rst + 1)) begin
                rst = 1'b1;
                #1;
                check_all_zero("midrst");
                rst = 1'b0;
                model_reset();
                n_rst++;
            end

            @(negedge clk);
            idle = !inflight;
            both = v[0] && v[1];
            sel  = both ? ~last : v[1];
            er0  = idle && v[0] && !sel;
            er1  = idle && v[1] &&  sel;
            ev0  = inflight && (cyc >= resp_start) && !owner;
            ev1  = inflight && (cyc >= resp_start) &&  owner;

            chk("req0_ready",  req0_ready,  er0);
            chk("req1_ready",  req1_ready,  er1);
            chk("resp0_valid", resp0_valid, ev0);
            chk("resp1_valid", resp1_valid, ev1);
            chk("busy",        busy,        inflight);
            chk("alu_opcode",  alu_opcode,  e_op);
            chk("alu_a",       alu_a,       e_a);
            chk("alu_b",       alu_b,       e_b);
            if (ev0) begin
                chk("resp0_result", resp0_result, e_res);
                chk("resp0_carry",  resp0_carry,  e_car);
                chk("resp0_err",    resp0_err,    e_err);
            end
            if (ev1) begin
                chk("resp1_result", resp1_result, e_res);
                chk("resp1_carry",  resp1_carry,  e_car);
                chk("resp1_err",    resp1_err,    e_err);
            end

            // Advance the model over the coming clock edge.
            if (er0 || er1) begin
                hs[sel] = 1'b1;
                owner = sel;
                e_op = p_op[sel]; e_a = p_a[sel]; e_b = p_b[sel];
                r = alu_fn(e_op, e_a, e_b);
                e_res = r[N-1:0]; e_car = r[N]; e_err = 1'b0;
                lat = (e_op == 4'b0010) ? MUL_C : (e_op == 4'b0011) ? MOD_C : 1;
`ifdef ALU_SCHED_DIVZERO_CHECK_EN
                if (e_op == 4'b0011 && e_b == '0) begin
                    lat = 1; e_res = '0; e_car = 1'b0; e_err = 1'b1;
                end
`endif
                inflight = 1'b1;
                resp_start = cyc + lat + 1;
            end else if ((ev0 && resp0_ready) || (ev1 && resp1_ready)) begin
                inflight = 1'b0;
                last = owner;
            end

            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one combinational 32-bit ALU (opcode[3:0], operandA, operandB -> result, carryout) between two requesters.
- Round-robin arbitration with valid/ready request and response handshakes.
- Holds operands stable for a per-opcode multi-cycle budget (mul, mod are slow paths), then registers result and carry back to the granted requester.
- Sits between the processor issue logic / coprocessor port and the ALU instance.

Parameters:
- N, 32, operand/result width.
- MUL_CYCLES, 2, cycles operands are held for opcode 0010 (mul); legal range 1..15.
- MOD_CYCLES, 4, cycles operands are held for opcode 0011 (mod); legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_opcode  in  4  ALU opcode.
- req0_a, req0_b  in  N  operands.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b: same as requester 0, for requester 1.
- resp0_valid  out  1  result available for requester 0.
- resp0_ready  in  1  requester 0 takes the result.
- resp0_result  out  N  registered result.
- resp0_carry  out  1  registered carryout.
- resp0_err  out  1  error flag (see Optional Feature).
- resp1_valid, resp1_ready, resp1_result, resp1_carry, resp1_err: same as requester 0, for requester 1.
- alu_opcode  out  4  to ALU.
- alu_a, alu_b  out  N  to ALU.
- alu_result  in  N  from ALU.
- alu_carry  in  1  from ALU.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=1 (requester 0 wins first), counter=0.
  - Opcode/operand/result/carry/err registers = 0.
  - All ready/valid outputs = 0, busy=0.
  - Reset mid-operation aborts it; no response is ever produced for the aborted op.
- States:
  - IDLE: if no valid, stay.
    - If only one valid, grant it.
    - If both valid, grant the requester not equal to last_grant.
    - reqX_ready=1 combinationally, only for the granted requester, only in IDLE.
    - On handshake, latch opcode/a/b into the issue registers and record grant.
    - Load counter = latency-1; go EXEC.
  - EXEC: alu_opcode/alu_a/alu_b driven only from the issue registers, stable for the whole op.
    - Counter decrements each cycle.
    - When counter==0, capture alu_result/alu_carry into the result registers; go RESP.
  - RESP: respX_valid=1 for the granted requester only; result/carry/err held stable.
    - When respX_ready=1, go IDLE and set last_grant=grant.
    - Response valid never drops without ready.
- Latency (cycles in EXEC):
  - 0010 (mul): MUL_CYCLES.
  - 0011 (mod): MOD_CYCLES.
  - All other opcodes, including unimplemented 0110, 0111, 1010-1111: 1.
- Unimplemented opcodes are issued unchanged; the ALU returns 0, carry 0.
- Minimum handshake-to-resp_valid latency = latency+1 cycles (accept edge, then EXEC cycles). Back-to-back throughput: one op per latency+2 cycles.
- alu_* outputs in IDLE/RESP keep the last issued values (no toggling).
- New request valid during EXEC/RESP: ready stays 0; the request waits.
- resp_ready asserted while resp_valid=0 is ignored.

Optional Feature:
- Macro: ALU_SCHED_DIVZERO_CHECK_EN.
- Defined:
  - At accept, opcode 0011 with b==0 skips the mod path: EXEC lasts 1 cycle.
  - Captured result forced to 0, carry 0, respX_err=1.
  - err cleared on the next accept.
- Not defined:
  - respX_err tied 0.
  - mod-by-zero executes normally for MOD_CYCLES and returns whatever the ALU produces.

Test Plan:
- Reset then req0 add a=0xFFFFFFFF b=0x1 -> req0_ready pulse 1 cycle; resp0_valid 2 cycles after accept; result=0x0, carry=1; resp1_valid stays 0.
- req0 and req1 valid same cycle (sub 10-3 / sll 1<<4), both responses ready=1 -> req0 served first (result 7); then req1 (result 0x10).
- Hold both valid continuously for 4 ops -> grant order 0,1,0,1.
- req1 mul 7*6 with MUL_CYCLES=2 -> alu_a/alu_b stable 2 EXEC cycles; resp1_result=42 exactly 3 cycles after accept.
- resp0_ready held 0 for 5 cycles with req1 valid -> resp0_valid and result stable throughout; req1_ready=0 until the cycle after resp0 handshake.
- Assert rst during EXEC of mod 100%7 -> all outputs 0 immediately; no response after release.
- With ALU_SCHED_DIVZERO_CHECK_EN: mod 5%0 -> err=1, result 0, resp after 2 cycles.
